// File: rtl/obi_program_loader.sv
// obi_program_loader
// Takes a base address and a stream of 32-bit words from the host register
// block and writes them into memory over OBI. Each accepted word is buffered
// in a small FIFO together with its target address. The address pointer
// advances by 4 per word. At most one OBI write is outstanding at a time.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   base_addr_i, addr_valid_i   base address load (1-cycle strobe)
//   word_i, word_valid_i        word push (1-cycle strobe)
//   clear_i                     synchronous flush of queue, counter and flags
//   req_o, we_o, be_o,
//   addr_o, wdata_o             registered OBI request channel
//   gnt_i, rvalid_i             OBI grant / response
//   busy_o, full_o              transfer pending or in flight / FIFO full
//   words_done_o                completed (responded) writes, saturating
//   overflow_o, addr_err_o,
//   proto_err_o                 sticky error flags

module obi_program_loader #(
   parameter int pDATA_WIDTH = 32,
   parameter int pADDR_WIDTH = 32,
   parameter int pFIFO_DEPTH = 4,
   parameter int pCNT_WIDTH  = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [pADDR_WIDTH-1:0] base_addr_i,
   input  logic                   addr_valid_i,
   input  logic [pDATA_WIDTH-1:0] word_i,
   input  logic                   word_valid_i,
   input  logic                   clear_i,
   output logic                   req_o,
   output logic                   we_o,
   output logic [3:0]             be_o,
   output logic [pADDR_WIDTH-1:0] addr_o,
   output logic [pDATA_WIDTH-1:0] wdata_o,
   input  logic                   gnt_i,
   input  logic                   rvalid_i,
   output logic                   busy_o,
   output logic                   full_o,
   output logic [pCNT_WIDTH-1:0]  words_done_o,
   output logic                   overflow_o,
   output logic                   addr_err_o,
   output logic                   proto_err_o
);

   localparam int cPtrW = $clog2(pFIFO_DEPTH);
   localparam logic [cPtrW:0] cDepth = (cPtrW+1)'(pFIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t state_q, state_d;

   logic [pADDR_WIDTH-1:0] fifoAddr [pFIFO_DEPTH];
   logic [pDATA_WIDTH-1:0] fifoData [pFIFO_DEPTH];
   logic [cPtrW-1:0]       wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
   logic [cPtrW:0]         count_q, count_d;

   logic [pADDR_WIDTH-1:0] addrPtr_q, addrPtr_d;
   logic                   req_q, req_d;
   logic [pADDR_WIDTH-1:0] addr_q, addr_d;
   logic [pDATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [pCNT_WIDTH-1:0]  wordsDone_q, wordsDone_d;
   logic                   overflow_q, overflow_d;
   logic                   addrErr_q, addrErr_d;
   logic                   protoErr_q, protoErr_d;
   logic                   skipResp_q, skipResp_d;
   logic                   headFlushed_q, headFlushed_d;

   logic                   fifoEmpty, fifoFull, addrAccept, pushOk, popOk, rspOk;
   logic [pADDR_WIDTH-1:0] pushAddr;

   // Handshake qualifiers. headFlushed_q marks a request whose FIFO entry was
   // flushed by clear_i while it was being presented: its grant must not pop
   // whatever has been pushed into the FIFO since.
   always_comb begin
      fifoEmpty  = (count_q == '0);
      fifoFull   = (count_q == cDepth);
      addrAccept = addr_valid_i && fifoEmpty && (state_q == IDLE) && !clear_i;
      pushAddr   = addrAccept ? (base_addr_i & ~pADDR_WIDTH'(3)) : addrPtr_q;
      popOk      = (state_q == REQ) && gnt_i && !clear_i && !headFlushed_q;
      pushOk     = word_valid_i && !clear_i && (!fifoFull || popOk);
      rspOk      = (state_q == WAIT) && rvalid_i;
   end

   // Next-state logic of the request sequencer.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (!fifoEmpty && !clear_i) state_d = REQ;
         REQ:  if (gnt_i) state_d = WAIT;
         WAIT: if (rvalid_i) state_d = (!fifoEmpty && !clear_i) ? REQ : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Request registers load the FIFO head when entering REQ and then hold,
   // so address and data stay stable until granted.
   always_comb begin
      req_d   = (state_d == REQ);
      addr_d  = addr_q;
      wdata_d = wdata_q;
      if ((state_d == REQ) && (state_q != REQ)) begin
         addr_d  = fifoAddr[rdPtr_q];
         wdata_d = fifoData[rdPtr_q];
      end
   end

   // FIFO pointers, address pointer, counter and sticky flags.
   always_comb begin
      wrPtr_d       = wrPtr_q;
      rdPtr_d       = rdPtr_q;
      count_d       = count_q;
      addrPtr_d     = addrPtr_q;
      wordsDone_d   = wordsDone_q;
      overflow_d    = overflow_q;
      addrErr_d     = addrErr_q;
      protoErr_d    = protoErr_q;
      skipResp_d    = skipResp_q;
      headFlushed_d = headFlushed_q;
      if (clear_i) begin
         wrPtr_d       = '0;
         rdPtr_d       = '0;
         count_d       = '0;
         addrPtr_d     = '0;
         wordsDone_d   = '0;
         overflow_d    = 1'b0;
         addrErr_d     = 1'b0;
         protoErr_d    = 1'b0;
         skipResp_d    = (state_q == REQ) || ((state_q == WAIT) && !rvalid_i);
         headFlushed_d = (state_q == REQ) && !gnt_i;
      end else begin
         if (pushOk) wrPtr_d = wrPtr_q + cPtrW'(1);
         if (popOk)  rdPtr_d = rdPtr_q + cPtrW'(1);
         if (pushOk && !popOk) count_d = count_q + (cPtrW+1)'(1);
         if (!pushOk && popOk) count_d = count_q - (cPtrW+1)'(1);
         addrPtr_d = pushOk ? (pushAddr + pADDR_WIDTH'(4)) : pushAddr;
         if (word_valid_i && !pushOk)      overflow_d = 1'b1;
         if (addr_valid_i && !addrAccept)  addrErr_d  = 1'b1;
         if (rvalid_i && (state_q != WAIT)) protoErr_d = 1'b1;
         if (rspOk) begin
            if (!skipResp_q && !(&wordsDone_q)) wordsDone_d = wordsDone_q + pCNT_WIDTH'(1);
            skipResp_d = 1'b0;
         end
         if ((state_q == REQ) && gnt_i) headFlushed_d = 1'b0;
      end
   end

   // FIFO storage; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (pushOk) begin
         fifoAddr[wrPtr_q] <= pushAddr;
         fifoData[wrPtr_q] <= word_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         wrPtr_q       <= '0;
         rdPtr_q       <= '0;
         count_q       <= '0;
         addrPtr_q     <= '0;
         req_q         <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         wordsDone_q   <= '0;
         overflow_q    <= 1'b0;
         addrErr_q     <= 1'b0;
         protoErr_q    <= 1'b0;
         skipResp_q    <= 1'b0;
         headFlushed_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         wrPtr_q       <= wrPtr_d;
         rdPtr_q       <= rdPtr_d;
         count_q       <= count_d;
         addrPtr_q     <= addrPtr_d;
         req_q         <= req_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         wordsDone_q   <= wordsDone_d;
         overflow_q    <= overflow_d;
         addrErr_q     <= addrErr_d;
         protoErr_q    <= protoErr_d;
         skipResp_q    <= skipResp_d;
         headFlushed_q <= headFlushed_d;
      end
   end

   assign req_o        = req_q;
   assign we_o         = req_q;
   assign be_o         = {4{req_q}};
   assign addr_o       = addr_q;
   assign wdata_o      = wdata_q;
   assign busy_o       = (state_q != IDLE) || !fifoEmpty;
   assign full_o       = fifoFull;
   assign words_done_o = wordsDone_q;
   assign overflow_o   = overflow_q;
   assign addr_err_o   = addrErr_q;
   assign proto_err_o  = protoErr_q;

endmodule

// File: tb/tb_obi_program_loader.sv
// Testbench for obi_program_loader: directed scenarios followed by a random
// phase. A behavioural model predicts the sequence of OBI writes and the
// status outputs; a monitor compares them against the DUT every cycle.

module tb_obi_program_loader;

   localparam int cDepth = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] base_addr_i;
   logic        addr_valid_i;
   logic [31:0] word_i;
   logic        word_valid_i;
   logic        clear_i;
   logic        req_o, we_o;
   logic [3:0]  be_o;
   logic [31:0] addr_o, wdata_o;
   logic        gnt_i, rvalid_i;
   logic        busy_o, full_o;
   logic [15:0] words_done_o;
   logic        overflow_o, addr_err_o, proto_err_o;

   obi_program_loader #(
      .pDATA_WIDTH(32), .pADDR_WIDTH(32), .pFIFO_DEPTH(cDepth), .pCNT_WIDTH(16)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .base_addr_i(base_addr_i), .addr_valid_i(addr_valid_i),
      .word_i(word_i), .word_valid_i(word_valid_i), .clear_i(clear_i),
      .req_o(req_o), .we_o(we_o), .be_o(be_o), .addr_o(addr_o), .wdata_o(wdata_o),
      .gnt_i(gnt_i), .rvalid_i(rvalid_i),
      .busy_o(busy_o), .full_o(full_o), .words_done_o(words_done_o),
      .overflow_o(overflow_o), .addr_err_o(addr_err_o), .proto_err_o(proto_err_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } write_t;

   int checks = 0;
   int errors = 0;

   // Reference model state: writes expected on the bus in order, words held
   // in the buffer, load pointer, completed count and sticky flags.
   write_t      writeQ[$];
   int          mCount = 0;
   logic [31:0] mPtr = '0;
   logic [15:0] mDone = '0;
   bit mOverflow = 0, mAddrErr = 0, mProto = 0;
   bit mOutstanding = 0, mSkip = 0, mFlushedHead = 0;
   bit modelOn = 0;

   // Slave behaviour knobs.
   int gntPct = 100;
   int maxDelay = 0;
   bit strayRvalid = 0;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   // One-cycle pulse on the host-side inputs; called at posedge+1.
   task automatic applyStimulus(input bit av, input logic [31:0] base, input bit wv,
                                input logic [31:0] word, input bit clr);
      addr_valid_i = av;
      base_addr_i  = base;
      word_valid_i = wv;
      word_i       = word;
      clear_i      = clr;
      @(posedge clk); #1;
      addr_valid_i = 1'b0;
      word_valid_i = 1'b0;
      clear_i      = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic waitIdle(input int budget);
      int k = 0;
      while ((writeQ.size() != 0 || mOutstanding || req_o) && k < budget) begin
         @(posedge clk); #1;
         k++;
      end
      if (k >= budget) begin
         checks++;
         errors++;
         $display("[TB] FAIL waitIdle: timed out after %0d cycles, %0d writes pending", budget, writeQ.size());
      end
      idleCycles(1);
   endtask

   // OBI slave: random grant, response a random 0..maxDelay cycles after
   // the cycle following the grant, optional injected stray response.
   initial begin : slave
      bit hs;
      int respCnt;
      respCnt  = -1;
      gnt_i    = 1'b0;
      rvalid_i = 1'b0;
      forever begin
         @(negedge clk);
         hs = req_o && gnt_i && rst_n;
         @(posedge clk); #2;
         rvalid_i = 1'b0;
         if (hs) respCnt = $urandom_range(maxDelay, 0);
         if (respCnt == 0) begin
            rvalid_i = 1'b1;
            respCnt  = -1;
         end else if (respCnt > 0) begin
            respCnt--;
         end
         if (strayRvalid) rvalid_i = 1'b1;
         gnt_i = (int'($urandom_range(99, 0)) < gntPct);
      end
   end

   // Monitor and model: compare the cycle's outputs, then apply this
   // cycle's inputs to the model for the coming edge.
   initial begin : monitor
      bit hs, rsp, stray, idleNow, pop, preOut;
      write_t w;
      forever begin
         @(negedge clk);
         if (rst_n && modelOn) begin
            checkOutput("wordsDone", words_done_o, mDone);
            checkOutput("overflow", overflow_o, mOverflow);
            checkOutput("addrErr", addr_err_o, mAddrErr);
            checkOutput("protoErr", proto_err_o, mProto);
            checkOutput("full", full_o, (mCount == cDepth));
            checkOutput("busy", busy_o, ((mCount != 0) || req_o || mOutstanding));
            if (req_o) begin
               if (writeQ.size() == 0) begin
                  checkOutput("reqSpurious", req_o, 0);
               end else begin
                  checkOutput("reqAddr", addr_o, writeQ[0].addr);
                  checkOutput("reqData", wdata_o, writeQ[0].data);
                  checkOutput("reqWeBe", {we_o, be_o}, 5'h1F);
               end
            end else begin
               checkOutput("idleWeBe", {we_o, be_o}, 0);
            end

            hs      = req_o && gnt_i;
            preOut  = mOutstanding;
            rsp     = rvalid_i && preOut;
            stray   = rvalid_i && !preOut;
            idleNow = !req_o && !preOut;
            pop     = hs && !mFlushedHead && !clear_i;
            if (hs && writeQ.size() != 0) void'(writeQ.pop_front());
            if (rsp) mOutstanding = 0;
            if (hs)  mOutstanding = 1;

            if (clear_i) begin
               mSkip     = req_o || (preOut && !rsp);
               mDone     = '0;
               mOverflow = 0;
               mAddrErr  = 0;
               mProto    = 0;
               mPtr      = '0;
               mCount    = 0;
               mFlushedHead = req_o && !hs;
               if (req_o && !hs && writeQ.size() != 0) begin
                  w = writeQ[0];
                  writeQ.delete();
                  writeQ.push_back(w);
               end else begin
                  writeQ.delete();
               end
            end else begin
               if (stray) mProto = 1;
               if (rsp) begin
                  if (!mSkip && mDone != 16'hFFFF) mDone = mDone + 16'd1;
                  mSkip = 0;
               end
               if (hs) mFlushedHead = 0;
               if (addr_valid_i) begin
                  if (mCount == 0 && idleNow) mPtr = base_addr_i & 32'hFFFF_FFFC;
                  else mAddrErr = 1;
               end
               if (word_valid_i) begin
                  if (mCount < cDepth || pop) begin
                     w.addr = mPtr;
                     w.data = word_i;
                     writeQ.push_back(w);
                     mPtr   = mPtr + 32'd4;
                     mCount++;
                  end else begin
                     mOverflow = 1;
                  end
               end
               if (pop) mCount--;
            end
         end
      end
   end

   initial begin : stimulus
      addr_valid_i = 1'b0;
      base_addr_i  = '0;
      word_valid_i = 1'b0;
      word_i       = '0;
      clear_i      = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rstReqWeBe", {req_o, we_o, be_o}, 0);
      checkOutput("rstAddr", addr_o, 0);
      checkOutput("rstWdata", wdata_o, 0);
      checkOutput("rstDone", words_done_o, 0);
      checkOutput("rstStatus", {busy_o, full_o, overflow_o, addr_err_o, proto_err_o}, 0);
      rst_n   = 1'b1;
      modelOn = 1;
      idleCycles(2);

      // Basic load of three words with immediate grant
      gntPct = 100;
      maxDelay = 0;
      applyStimulus(1, 32'h0000_1000, 0, 0, 0);
      applyStimulus(0, 0, 1, 32'h0000_000A, 0);
      checkOutput("reqLatencyEarly", req_o, 0);
      applyStimulus(0, 0, 1, 32'h0000_000B, 0);
      checkOutput("reqLatency", req_o, 1);
      applyStimulus(0, 0, 1, 32'h0000_000C, 0);
      waitIdle(100);
      checkOutput("basicDone", words_done_o, 3);
      checkOutput("basicBusy", busy_o, 0);

      // Stalled grant: request must hold steady
      gntPct = 0;
      idleCycles(1);
      applyStimulus(0, 0, 1, 32'h1234_5678, 0);
      idleCycles(6);
      checkOutput("stallReq", req_o, 1);
      checkOutput("stallAddr", addr_o, 32'h0000_100C);
      gntPct = 100;
      waitIdle(100);
      checkOutput("stallDone", words_done_o, 4);

      // Overflow: five pushes into a stalled four-entry buffer
      gntPct = 0;
      idleCycles(1);
      for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 32'hD000_0000 + i, 0);
      checkOutput("ovfFull", full_o, 1);
      checkOutput("ovfFlag", overflow_o, 1);
      gntPct = 100;
      maxDelay = 2;
      waitIdle(200);
      checkOutput("ovfDone", words_done_o, 8);

      // Address wrap
      gntPct = 0;
      idleCycles(1);
      applyStimulus(1, 32'hFFFF_FFFE, 1, 32'hAAAA_0001, 0);
      idleCycles(2);
      checkOutput("wrapAddr0", addr_o, 32'hFFFF_FFFC);
      gntPct = 100;
      applyStimulus(0, 0, 1, 32'hAAAA_0002, 0);
      waitIdle(100);
      checkOutput("wrapDone", words_done_o, 10);

      // Address load while busy, then a stray response in idle
      gntPct = 0;
      idleCycles(1);
      applyStimulus(1, 32'h0000_3000, 1, 32'hBEEF_0001, 0);
      idleCycles(2);
      applyStimulus(1, 32'h0000_5000, 0, 0, 0);
      checkOutput("addrErrFlag", addr_err_o, 1);
      gntPct = 100;
      applyStimulus(0, 0, 1, 32'hBEEF_0002, 0);
      waitIdle(100);
      strayRvalid = 1;
      idleCycles(1);
      strayRvalid = 0;
      idleCycles(1);
      checkOutput("protoFlag", proto_err_o, 1);
      checkOutput("protoDone", words_done_o, 12);

      // Clear while a request is presented with more words queued
      gntPct = 0;
      idleCycles(1);
      applyStimulus(1, 32'h0000_2000, 1, 32'hC0DE_0001, 0);
      applyStimulus(0, 0, 1, 32'hC0DE_0002, 0);
      applyStimulus(0, 0, 1, 32'hC0DE_0003, 0);
      idleCycles(2);
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("clrReqHeld", req_o, 1);
      gntPct = 100;
      waitIdle(100);
      checkOutput("clrDone", words_done_o, 0);
      checkOutput("clrBusy", busy_o, 0);
      checkOutput("clrFlags", {overflow_o, addr_err_o, proto_err_o}, 0);

      // Random traffic
      for (int c = 0; c < 600; c++) begin
         bit av, wv, clr;
         int r;
         if (c % 50 == 0) begin
            gntPct   = $urandom_range(100, 20);
            maxDelay = $urandom_range(2, 0);
         end
         r   = $urandom_range(99, 0);
         av  = (r < 6);
         wv  = ($urandom_range(99, 0) < 55);
         clr = ($urandom_range(199, 0) < 3);
         applyStimulus(av, $urandom, wv, $urandom, clr);
      end
      gntPct = 100;
      waitIdle(500);

      // Reset during a stalled transfer
      gntPct = 0;
      idleCycles(1);
      applyStimulus(0, 0, 1, 32'h5555_AAAA, 0);
      idleCycles(3);
      checkOutput("preRstReq", req_o, 1);
      modelOn = 0;
      rst_n = 1'b0;
      #1;
      checkOutput("midRstReq", {req_o, we_o, be_o}, 0);
      checkOutput("midRstStatus", {busy_o, full_o}, 0);
      idleCycles(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
